// File: rtl/dm_param.sv
`default_nettype none
// ============================================================================
// Module   : dm_param
// Purpose  : Parametrised data memory for the CPU datapath.
//            - CPU port: combinational read, synchronous byte-masked write.
//            - Hardware init sequencer fills every word with FILL_VALUE
//              after reset, one word per cycle (DEPTH cycles total).
//            - Registered debug/display read port with a one-cycle valid.
//            - 'drop' pulses for one cycle after any CPU write that was
//              ignored (during init, or address out of range).
// Ports    : clk        system clock, rising edge
//            reset      asynchronous active-high reset
//            addr       CPU read/write address
//            din        CPU write data
//            we         CPU write strobe
//            be         byte enables, bit i gates din[8i+7:8i]
//            dout       CPU read data (combinational from addr)
//            ready      high once init has completed
//            drop       registered pulse: a CPU write was ignored
//            readAddr   debug read address
//            readReq    debug read request
//            readData   registered debug read data
//            readValid  high one cycle after an accepted readReq
// Revision : 1.0  initial release
// ============================================================================
module dm_param #(
    parameter int                DATA_W     = 16,
    parameter int                ADDR_W     = 8,
    parameter int                DEPTH      = 256,
    parameter logic [DATA_W-1:0] FILL_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     din,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   be,
    output logic [DATA_W-1:0]     dout,
    output logic                  ready,
    output logic                  drop,
    input  logic [ADDR_W-1:0]     readAddr,
    input  logic                  readReq,
    output logic [DATA_W-1:0]     readData,
    output logic                  readValid
);

    localparam int BYTES = DATA_W / 8;
    // Index width actually needed to address DEPTH words.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // DEPTH widened by one bit so DEPTH == 2**ADDR_W compares correctly.
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Storage. Not reset: contents survive reset and are overwritten by
    // the init sequencer instead.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem [0:DEPTH-1];

    state_t            state;
    logic [ADDR_W-1:0] ptr;

    // Address decode for both ports.
    logic              cpu_in_range;
    logic              dbg_in_range;
    logic [IDX_W-1:0]  cpu_idx;
    logic [IDX_W-1:0]  dbg_idx;

    assign cpu_in_range = ({1'b0, addr}     < DEPTH_EXT);
    assign dbg_in_range = ({1'b0, readAddr} < DEPTH_EXT);
    assign cpu_idx      = addr[IDX_W-1:0];
    assign dbg_idx      = readAddr[IDX_W-1:0];

    // ------------------------------------------------------------------
    // Write-port mux: the init sequencer owns the write port while in
    // INIT (full-word writes of FILL_VALUE); the CPU owns it in RUN.
    // ------------------------------------------------------------------
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic [BYTES-1:0]  wr_be;

    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = cpu_idx;
        wr_data = din;
        wr_be   = be;
        if (state == INIT) begin
            wr_en   = 1'b1;
            wr_idx  = ptr[IDX_W-1:0];
            wr_data = FILL_VALUE;
            wr_be   = '1;
        end else begin
            wr_en   = we && cpu_in_range;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < BYTES; i++) begin
                if (wr_be[i]) begin
                    mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // CPU read: gated to zero until init completes and for unmapped
    // addresses, so the CPU never observes partially-filled memory.
    assign dout = (ready && cpu_in_range) ? mem[cpu_idx] : '0;

    // ------------------------------------------------------------------
    // Control FSM with registered status and debug outputs.
    // The debug read samples mem with a non-blocking assignment on the
    // same edge as any CPU write, so a same-address collision returns
    // the pre-write word.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= INIT;
            ptr       <= '0;
            ready     <= 1'b0;
            drop      <= 1'b0;
            readValid <= 1'b0;
            readData  <= '0;
        end else begin
            case (state)
                INIT: begin
                    // Every CPU write attempt is refused while filling.
                    drop      <= we;
                    readValid <= 1'b0;
                    if (ptr == LAST_PTR) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end else begin
                        ptr   <= ptr + 1'b1;
                    end
                end
                RUN: begin
                    // A zero byte-enable write is a legal no-op, only an
                    // unmapped address counts as a dropped write here.
                    drop <= we && !cpu_in_range;
                    if (readReq) begin
                        readData  <= dbg_in_range ? mem[dbg_idx] : '0;
                        readValid <= 1'b1;
                    end else begin
                        readValid <= 1'b0;
                    end
                end
                default: begin
                    state <= INIT;
                    ptr   <= '0;
                    ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dm_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_param
// Purpose  : Self-checking bench for dm_param. Two instances share clock and
//            reset: A (DEPTH=256, fill 0) and B (DEPTH=200, fill 16'h5A5A).
//            Debug-port responses are checked by scoreboard monitors.
// Revision : 1.0  initial release
// ============================================================================
module tb_dm_param;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Instance A signals
    logic [7:0]  a_addr, a_readAddr;
    logic [15:0] a_din, a_dout, a_readData;
    logic        a_we, a_ready, a_drop, a_readReq, a_readValid;
    logic [1:0]  a_be;
    // Instance B signals
    logic [7:0]  b_addr, b_readAddr;
    logic [15:0] b_din, b_dout, b_readData;
    logic        b_we, b_ready, b_drop, b_readReq, b_readValid;
    logic [1:0]  b_be;

    dm_param #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .FILL_VALUE(16'h0000)) u_a (
        .clk(clk), .reset(reset), .addr(a_addr), .din(a_din), .we(a_we), .be(a_be),
        .dout(a_dout), .ready(a_ready), .drop(a_drop), .readAddr(a_readAddr),
        .readReq(a_readReq), .readData(a_readData), .readValid(a_readValid)
    );

    dm_param #(.DATA_W(16), .ADDR_W(8), .DEPTH(200), .FILL_VALUE(16'h5A5A)) u_b (
        .clk(clk), .reset(reset), .addr(b_addr), .din(b_din), .we(b_we), .be(b_be),
        .dout(b_dout), .ready(b_ready), .drop(b_drop), .readAddr(b_readAddr),
        .readReq(b_readReq), .readData(b_readData), .readValid(b_readValid)
    );

    int compared   = 0;
    int mismatched = 0;

    logic [15:0] a_q[$];
    logic [15:0] b_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitors for the debug read ports.
    initial begin
        forever begin
            @(negedge clk);
            if (a_readValid) begin
                if (a_q.size() == 0) chk("a_unexpected_valid", 32'(a_readValid), 32'd0);
                else chk("a_dbg_data", 32'(a_readData), 32'(a_q.pop_front()));
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (b_readValid) begin
                if (b_q.size() == 0) chk("b_unexpected_valid", 32'(b_readValid), 32'd0);
                else chk("b_dbg_data", 32'(b_readData), 32'(b_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bn;
        reset = 1'b1;
        a_addr = '0; a_din = '0; a_we = 1'b0; a_be = '0; a_readAddr = '0; a_readReq = 1'b0;
        b_addr = '0; b_din = '0; b_we = 1'b0; b_be = '0; b_readAddr = '0; b_readReq = 1'b0;
        repeat (3) step();

        chk("rst_ready",     32'(a_ready),     32'd0);
        chk("rst_drop",      32'(a_drop),      32'd0);
        chk("rst_readValid", 32'(a_readValid), 32'd0);
        chk("rst_readData",  32'(a_readData),  32'd0);
        chk("rst_b_ready",   32'(b_ready),     32'd0);

        // First init: write attempt and debug request at cycle 10.
        reset = 1'b0;
        repeat (10) step();
        a_we = 1'b1; a_addr = 8'h0A; a_din = 16'hFFFF; a_be = 2'b11;
        a_readReq = 1'b1; a_readAddr = 8'h0A;
        b_addr = 8'h00;
        #1 chk("init_b_dout_zero", 32'(b_dout), 32'd0);
        step();
        chk("init_drop",  32'(a_drop),  32'd1);
        chk("init_ready", 32'(a_ready), 32'd0);
        a_we = 1'b0; a_readReq = 1'b0;
        step();
        chk("init_drop_clear", 32'(a_drop), 32'd0);
        repeat (88) step();

        // Reset at init cycle 100: init must restart from scratch.
        reset = 1'b1;
        #1 chk("midinit_rst_ready", 32'(a_ready), 32'd0);
        step(); step();
        reset = 1'b0;
        n = 0; bn = 0;
        while (!a_ready && n < 400) begin
            step();
            n++;
            if (b_ready && bn == 0) bn = n;
        end
        chk("a_init_len", 32'(n),  32'd256);
        chk("b_init_len", 32'(bn), 32'd200);

        // Filled contents, including the location written during init.
        a_addr = 8'h0A; #1 chk("a_fill_0a", 32'(a_dout), 32'h0000);
        a_addr = 8'hFF; #1 chk("a_fill_ff", 32'(a_dout), 32'h0000);
        a_addr = 8'h05; #1 chk("a_fill_05", 32'(a_dout), 32'h0000);

        // Byte-lane writes.
        a_we = 1'b1; a_din = 16'h10C3; a_be = 2'b11;
        step(); a_we = 1'b0;
        chk("a_wr_full", 32'(a_dout), 32'h10C3);
        a_we = 1'b1; a_din = 16'hABCD; a_be = 2'b01;
        step(); a_we = 1'b0;
        chk("a_wr_lo", 32'(a_dout), 32'h10CD);
        chk("a_wr_nodrop", 32'(a_drop), 32'd0);

        // Debug read colliding with a CPU write: old word, then new word.
        a_readReq = 1'b1; a_readAddr = 8'h05;
        a_we = 1'b1; a_din = 16'h0127; a_be = 2'b11;
        a_q.push_back(16'h10CD);
        step(); a_we = 1'b0;
        a_q.push_back(16'h0127);
        step(); a_readReq = 1'b0;
        step();
        chk("a_dout_after_dbg", 32'(a_dout), 32'h0127);

        // Zero byte-enable write is a silent no-op.
        a_we = 1'b1; a_din = 16'hFFFF; a_be = 2'b00;
        step(); a_we = 1'b0;
        chk("a_be0_nodrop", 32'(a_drop), 32'd0);
        chk("a_be0_keep",   32'(a_dout), 32'h0127);
        a_we = 1'b1; a_din = 16'hAB00; a_be = 2'b10;
        step(); a_we = 1'b0;
        chk("a_wr_hi", 32'(a_dout), 32'hAB27);

        // Instance B: boundary and out-of-range behaviour.
        b_addr = 8'd199; #1 chk("b_fill_199", 32'(b_dout), 32'h5A5A);
        b_addr = 8'd210; #1 chk("b_oor_dout", 32'(b_dout), 32'h0000);
        b_we = 1'b1; b_din = 16'h1111; b_be = 2'b11;
        step();
        chk("b_oor_drop", 32'(b_drop), 32'd1);
        b_addr = 8'd200;
        step();
        chk("b_oor_drop_hold", 32'(b_drop), 32'd1);
        b_we = 1'b0;
        step();
        chk("b_drop_clear", 32'(b_drop), 32'd0);
        b_addr = 8'd210; #1 chk("b_oor_dout_after", 32'(b_dout), 32'h0000);
        b_addr = 8'd199; #1 chk("b_199_unchanged", 32'(b_dout), 32'h5A5A);

        b_readReq = 1'b1; b_readAddr = 8'd210;
        b_q.push_back(16'h0000);
        step();
        b_readAddr = 8'd199;
        b_q.push_back(16'h5A5A);
        step();
        b_readReq = 1'b0;
        step();

        b_we = 1'b1; b_addr = 8'd199; b_din = 16'h1234; b_be = 2'b11;
        step(); b_we = 1'b0;
        chk("b_wr_199_nodrop", 32'(b_drop), 32'd0);
        #1 chk("b_wr_199", 32'(b_dout), 32'h1234);

        repeat (3) step();
        chk("a_q_drained", 32'(a_q.size()), 32'd0);
        chk("b_q_drained", 32'(b_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dm_param.md
Name: dm_param

Overview:
- Parametrised data memory for the single-cycle/multi-cycle CPU datapath; successor to the fixed 256x16 data memory.
- CPU port: asynchronous read, synchronous write. Adds per-byte write enables and a hardware init sequencer that fills memory after reset.
- Adds a registered debug/display read port with a valid flag, and reports writes dropped while busy or out of range.

Parameters:
- DATA_W, 16, word width in bits; must be a multiple of 8.
- ADDR_W, 8, address width of both ports.
- DEPTH, 256, number of words; 1 <= DEPTH <= 2**ADDR_W.
- FILL_VALUE, 0, word written to every location by the init sequencer.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- addr  input  ADDR_W  CPU read/write address.
- din  input  DATA_W  CPU write data.
- we  input  1  CPU write strobe.
- be  input  DATA_W/8  byte enables; bit i gates din[8i+7:8i].
- dout  output  DATA_W  CPU read data, combinational from addr.
- ready  output  1  high once init is complete; CPU access is valid only while high.
- drop  output  1  one-cycle pulse: a write was ignored.
- readAddr  input  ADDR_W  debug read address.
- readReq  input  1  debug read request.
- readData  output  DATA_W  registered debug read data.
- readValid  output  1  high for one cycle, one clock after an accepted readReq.

Behaviour:
- Reset, asynchronous:
  - FSM goes to INIT and init pointer to 0.
  - ready=0, drop=0, readValid=0, readData=0.
  - Memory contents are not cleared by reset itself.
- FSM states: INIT, RUN.
- INIT:
  - Each cycle writes FILL_VALUE to mem[ptr], then ptr increments.
  - When ptr==DEPTH-1 is written, the next state is RUN and ready rises on that edge.
  - Init therefore takes exactly DEPTH cycles after reset deasserts.
- Reset asserted mid-INIT restarts at ptr=0. Reset in RUN re-enters INIT and refills the memory.
- During INIT:
  - Any CPU we=1 is ignored and pulses drop the next cycle.
  - dout is 0.
  - readReq is ignored, with no readValid.
- RUN, CPU write:
  - On a clock edge with we=1 and addr<DEPTH, each byte lane with be[i]=1 is updated; other lanes keep their value.
  - we=1 with be all-zero is a legal no-op and does not pulse drop.
  - we=1 with addr>=DEPTH is ignored and drop pulses.
- RUN, CPU read:
  - dout=mem[addr] combinationally when addr<DEPTH, else 0.
  - A write shows on dout from the cycle after the edge.
- RUN, debug read:
  - readReq=1 at an edge latches readData<=mem[readAddr], or 0 if readAddr>=DEPTH, and sets readValid=1 for the next cycle.
  - readReq=0 sets readValid=0; readData holds its last value.
  - Back-to-back requests give back-to-back valid data.
- Same-edge CPU write and debug read of the same address: readData returns the old (pre-write) word. Read-before-write, no forwarding.
- drop is registered: high for exactly one cycle after each offending edge. Consecutive offending writes hold it high.
- No combinational path from any input to ready, drop, readData or readValid.

Test Plan:
- Reset, DEPTH=256, FILL_VALUE=16'h0000 -> ready low for 256 cycles after reset release, high on cycle 256; all dout reads then return 16'h0000.
- RUN: write addr=8'h05 din=16'h10c3 be=2'b11, then din=16'hABCD be=2'b01 -> dout at 8'h05 reads 16'h10c3, then 16'h10CD.
- Debug port: readReq=1 readAddr=8'h05 for two cycles while the CPU writes 16'h0127 to 8'h05 on the first edge -> readValid high two cycles; readData 16'h10CD, then 16'h0127.
- DEPTH=200: write addr=8'd210 -> drop pulses one cycle, no memory change; dout at 8'd210 is 0; debug read of 8'd210 returns 0 with readValid.
- we=1 during INIT at cycle 10 -> drop pulses; after ready that location reads FILL_VALUE.
- Reset asserted at INIT cycle 100, released -> full 256-cycle INIT restarts; ready is not early.
